// File: rtl/meteor_pkg.sv
// rtl/meteor_pkg.sv - shared constants, slot record and FSM states for the meteor spawner
package meteor_pkg;

    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int POS_W     = 10;
    localparam int SPD_W     = 3;
    localparam int IDX_W     = 3;
    // Slot storage is always sized for the largest pool so a 3-bit index never overruns it.
    localparam int MAX_SLOTS = 8;

    typedef struct packed {
        logic             active;
        logic [POS_W-1:0] x;
        logic [POS_W-1:0] y;
        logic [SPD_W-1:0] vx;
        logic [SPD_W-1:0] vy;
        logic             dir;
    } meteor_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVE,
        ST_SPAWN
    } spawn_state_e;

    // Fold a raw random x seed back onto the visible width.
    function automatic logic [POS_W-1:0] wrap_spawn_x(
        input logic [POS_W-1:0] pos,
        input logic [POS_W:0]   limit
    );
        logic [POS_W:0] ext;
        ext = {1'b0, pos};
        if (ext < limit) begin
            wrap_spawn_x = pos;
        end else begin
            wrap_spawn_x = POS_W'(ext - limit);
        end
    endfunction

endpackage

// File: rtl/meteor_step.sv
// rtl/meteor_step.sv - combinational next position and off-screen test for one meteor slot
module meteor_step #(
    parameter int SCREEN_W = meteor_pkg::SCREEN_W,
    parameter int SCREEN_H = meteor_pkg::SCREEN_H
) (
    input  logic [meteor_pkg::POS_W-1:0] x,
    input  logic [meteor_pkg::POS_W-1:0] y,
    input  logic [meteor_pkg::SPD_W-1:0] vx,
    input  logic [meteor_pkg::SPD_W-1:0] vy,
    input  logic                         dir,
    output logic [meteor_pkg::POS_W-1:0] x_next,
    output logic [meteor_pkg::POS_W-1:0] y_next,
    output logic                         off_screen
);
    import meteor_pkg::*;

    localparam logic [POS_W:0] W_LIM = (POS_W+1)'(SCREEN_W);
    localparam logic [POS_W:0] H_LIM = (POS_W+1)'(SCREEN_H);

    logic [POS_W:0]   vx_ext;
    logic [POS_W:0]   vy_ext;
    logic [POS_W:0]   x_sum;
    logic [POS_W:0]   y_sum;
    logic [POS_W-1:0] x_diff;
    logic             underflow;

    // Sums are one bit wider than a position so the edge compare sees the carry.
    always_comb begin
        vx_ext     = {{(POS_W+1-SPD_W){1'b0}}, vx};
        vy_ext     = {{(POS_W+1-SPD_W){1'b0}}, vy};
        x_sum      = {1'b0, x} + vx_ext;
        y_sum      = {1'b0, y} + vy_ext;
        x_diff     = x - vx_ext[POS_W-1:0];
        underflow  = ({1'b0, x} < vx_ext);
        y_next     = y_sum[POS_W-1:0];
        off_screen = (y_sum >= H_LIM);
        if (dir) begin
            x_next     = x_diff;
            off_screen = off_screen | underflow;
        end else begin
            x_next     = x_sum[POS_W-1:0];
            off_screen = off_screen | (x_sum >= W_LIM);
        end
    end

endmodule

// File: rtl/meteor_spawner.sv
// rtl/meteor_spawner.sv - meteor slot pool: per-frame move, retire and spawn sequencer
module meteor_spawner #(
    parameter int NUM_METEORS    = 4,
    parameter int SPAWN_INTERVAL = 32,
    parameter int SCREEN_W       = meteor_pkg::SCREEN_W,
    parameter int SCREEN_H       = meteor_pkg::SCREEN_H
) (
    input  logic                                     Clk,
    input  logic                                     Reset,
    input  logic                                     frame_tick,
    input  logic                                     enable,
    input  logic [meteor_pkg::POS_W-1:0]             rand_pos,
    input  logic [meteor_pkg::SPD_W-1:0]             rand_x_speed,
    input  logic [meteor_pkg::SPD_W-1:0]             rand_y_speed,
    input  logic                                     rand_sign,
    input  logic                                     kill_valid,
    input  logic [meteor_pkg::IDX_W-1:0]             kill_idx,
    output logic [NUM_METEORS*meteor_pkg::POS_W-1:0] meteor_x,
    output logic [NUM_METEORS*meteor_pkg::POS_W-1:0] meteor_y,
    output logic [NUM_METEORS-1:0]                   meteor_active,
    output logic                                     busy,
    output logic [15:0]                              spawn_count
);
    import meteor_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_METEORS-1);
    localparam logic [IDX_W:0]   NUM_LIM      = (IDX_W+1)'(NUM_METEORS);
    localparam logic [7:0]       TIMER_RELOAD = 8'(SPAWN_INTERVAL-1);
    localparam logic [POS_W:0]   W_LIM        = (POS_W+1)'(SCREEN_W);

    spawn_state_e     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      count_q, count_d;
    logic [7:0]       timer_q, timer_d;
    meteor_t          slots_q [MAX_SLOTS];
    meteor_t          slots_d [MAX_SLOTS];

    meteor_t          cur;
    logic [POS_W-1:0] step_x;
    logic [POS_W-1:0] step_y;
    logic             step_off;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;

    // One stepper serves every slot; the MOVE index selects which slot feeds it.
    assign cur = slots_q[idx_q];

    meteor_step #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_step (
        .x          (cur.x),
        .y          (cur.y),
        .vx         (cur.vx),
        .vy         (cur.vy),
        .dir        (cur.dir),
        .x_next     (step_x),
        .y_next     (step_y),
        .off_screen (step_off)
    );

    // Lowest-index inactive slot is the spawn target.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_METEORS-1; i >= 0; i--) begin
            if (!slots_q[i].active) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Sequencer next state: move slots one per cycle, then one spawn decision; kill applied last so it wins.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;
        timer_d = timer_q;
        for (int i = 0; i < MAX_SLOTS; i++) begin
            slots_d[i] = slots_q[i];
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_tick) begin
                    state_d = ST_MOVE;
                    idx_d   = '0;
                end
            end
            ST_MOVE: begin
                if (cur.active) begin
                    slots_d[idx_q].x = step_x;
                    slots_d[idx_q].y = step_y;
                    if (step_off) begin
                        slots_d[idx_q].active = 1'b0;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_SPAWN;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_SPAWN: begin
                state_d = ST_IDLE;
                if (timer_q != '0) begin
                    timer_d = timer_q - 8'd1;
                end else if (enable && free_found) begin
                    slots_d[free_idx].active = 1'b1;
                    slots_d[free_idx].x      = wrap_spawn_x(rand_pos, W_LIM);
                    slots_d[free_idx].y      = '0;
                    slots_d[free_idx].vx     = rand_x_speed;
                    slots_d[free_idx].vy     = (rand_y_speed == '0) ? SPD_W'(1) : rand_y_speed;
                    slots_d[free_idx].dir    = rand_sign;
                    count_d                  = count_q + 16'd1;
                    timer_d                  = TIMER_RELOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (kill_valid && ({1'b0, kill_idx} < NUM_LIM)) begin
            slots_d[kill_idx].active = 1'b0;
        end

        for (int i = NUM_METEORS; i < MAX_SLOTS; i++) begin
            slots_d[i] = '0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            count_q <= '0;
            timer_q <= TIMER_RELOAD;
            for (int i = 0; i < MAX_SLOTS; i++) begin
                slots_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            timer_q <= timer_d;
            for (int i = 0; i < MAX_SLOTS; i++) begin
                slots_q[i] <= slots_d[i];
            end
        end
    end

    // Flatten slot records onto the packed output buses.
    always_comb begin
        meteor_x      = '0;
        meteor_y      = '0;
        meteor_active = '0;
        for (int i = 0; i < NUM_METEORS; i++) begin
            meteor_x[i*POS_W +: POS_W] = slots_q[i].x;
            meteor_y[i*POS_W +: POS_W] = slots_q[i].y;
            meteor_active[i]           = slots_q[i].active;
        end
        busy        = (state_q != ST_IDLE);
        spawn_count = count_q;
    end

endmodule

// File: tb/tb_meteor_spawner.sv
// tb/tb_meteor_spawner.sv - scoreboard bench for meteor_spawner
module tb_meteor_spawner;
    localparam int NUM         = 4;
    localparam int INTERVAL    = 3;
    localparam int SW          = 640;
    localparam int SH          = 480;
    localparam int BUSY_CYCLES = NUM + 1;

    logic            Clk = 1'b0;
    logic            Reset = 1'b1;
    logic            frame_tick = 1'b0;
    logic            enable = 1'b0;
    logic [9:0]      rand_pos = '0;
    logic [2:0]      rand_x_speed = '0;
    logic [2:0]      rand_y_speed = '0;
    logic            rand_sign = 1'b0;
    logic            kill_valid = 1'b0;
    logic [2:0]      kill_idx = '0;
    logic [NUM*10-1:0] meteor_x;
    logic [NUM*10-1:0] meteor_y;
    logic [NUM-1:0]  meteor_active;
    logic            busy;
    logic [15:0]     spawn_count;

    always #5 Clk = ~Clk;

    meteor_spawner #(
        .NUM_METEORS    (NUM),
        .SPAWN_INTERVAL (INTERVAL),
        .SCREEN_W       (SW),
        .SCREEN_H       (SH)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .frame_tick    (frame_tick),
        .enable        (enable),
        .rand_pos      (rand_pos),
        .rand_x_speed  (rand_x_speed),
        .rand_y_speed  (rand_y_speed),
        .rand_sign     (rand_sign),
        .kill_valid    (kill_valid),
        .kill_idx      (kill_idx),
        .meteor_x      (meteor_x),
        .meteor_y      (meteor_y),
        .meteor_active (meteor_active),
        .busy          (busy),
        .spawn_count   (spawn_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: slot lists updated by the frame rules with plain integers.
    int m_x [NUM];
    int m_y [NUM];
    int m_vx [NUM];
    int m_vy [NUM];
    bit m_dir [NUM];
    bit m_act [NUM];
    int m_timer;
    int m_count;

    typedef struct {
        logic [NUM*10-1:0] x;
        logic [NUM*10-1:0] y;
        logic [NUM-1:0]    act;
        logic [15:0]       cnt;
    } snap_t;

    snap_t exp_q[$];

    function automatic void model_reset();
        for (int i = 0; i < NUM; i++) begin
            m_x[i] = 0; m_y[i] = 0; m_vx[i] = 0; m_vy[i] = 0; m_dir[i] = 0; m_act[i] = 0;
        end
        m_timer = INTERVAL - 1;
        m_count = 0;
    endfunction

    function automatic snap_t model_snap();
        snap_t s;
        for (int i = 0; i < NUM; i++) begin
            s.x[i*10 +: 10] = 10'(m_x[i]);
            s.y[i*10 +: 10] = 10'(m_y[i]);
            s.act[i]        = m_act[i];
        end
        s.cnt = 16'(m_count);
        return s;
    endfunction

    function automatic void model_frame(input logic [NUM-1:0] kmask, input int kspawn);
        int nx, ny, t;
        bit off;
        for (int i = 0; i < NUM; i++) begin
            if (m_act[i]) begin
                off = 0;
                ny  = m_y[i] + m_vy[i];
                if (m_dir[i]) begin
                    if (m_x[i] < m_vx[i]) off = 1;
                    nx = m_x[i] - m_vx[i];
                end else begin
                    nx = m_x[i] + m_vx[i];
                end
                if (ny >= SH || nx >= SW) off = 1;
                m_x[i] = nx & 1023;
                m_y[i] = ny & 1023;
                if (off) m_act[i] = 0;
            end
            if (kmask[i]) m_act[i] = 0;
        end
        if (m_timer != 0) begin
            m_timer--;
        end else if (enable) begin
            t = -1;
            for (int i = NUM-1; i >= 0; i--) if (!m_act[i]) t = i;
            if (t >= 0) begin
                m_x[t]   = (int'(rand_pos) >= SW) ? int'(rand_pos) - SW : int'(rand_pos);
                m_y[t]   = 0;
                m_vx[t]  = int'(rand_x_speed);
                m_vy[t]  = (rand_y_speed == 0) ? 1 : int'(rand_y_speed);
                m_dir[t] = rand_sign;
                m_act[t] = 1;
                m_count  = (m_count + 1) % 65536;
                m_timer  = INTERVAL - 1;
            end
        end
        if (kspawn >= 0 && kspawn < NUM) m_act[kspawn] = 0;
    endfunction

    task automatic set_rand(input int pos, input int xs, input int ys, input int sg);
        rand_pos     = 10'(pos);
        rand_x_speed = 3'(xs);
        rand_y_speed = 3'(ys);
        rand_sign    = 1'(sg);
    endtask

    // One frame: kmask kills slot k during its MOVE cycle, kspawn kills during the SPAWN cycle.
    task automatic run_frame(input logic [NUM-1:0] kmask, input int kspawn, input bit extra);
        model_frame(kmask, kspawn);
        exp_q.push_back(model_snap());
        @(negedge Clk); frame_tick = 1'b1;
        @(negedge Clk); frame_tick = 1'b0;
        for (int k = 0; k < NUM; k++) begin
            kill_valid = kmask[k];
            kill_idx   = 3'(k);
            frame_tick = extra && (k == 1);
            @(negedge Clk);
        end
        frame_tick = 1'b0;
        kill_valid = (kspawn >= 0);
        kill_idx   = 3'(kspawn);
        @(negedge Clk);
        kill_valid = 1'b0;
    endtask

    task automatic kill_idle(input int k);
        @(negedge Clk); kill_valid = 1'b1; kill_idx = 3'(k);
        @(negedge Clk); kill_valid = 1'b0;
        if (k < NUM) m_act[k] = 0;
    endtask

    // Monitor: on each busy falling edge, compare DUT slots with the oldest expected frame.
    bit prev_busy = 1'b0;
    int bcnt = 0;
    always @(negedge Clk) begin
        snap_t e;
        if (Reset) begin
            prev_busy = 1'b0;
            bcnt      = 0;
        end else begin
            if (busy) begin
                bcnt++;
            end else if (prev_busy) begin
                check("busy_width", 64'(bcnt), 64'(BUSY_CYCLES));
                bcnt = 0;
                if (exp_q.size() == 0) begin
                    check("unexpected_frame_end", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_x", 64'(meteor_x), 64'(e.x));
                    check("frame_y", 64'(meteor_y), 64'(e.y));
                    check("frame_active", 64'(meteor_active), 64'(e.act));
                    check("frame_count", 64'(spawn_count), 64'(e.cnt));
                end
            end
            prev_busy = busy;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded 500000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NUM-1:0] km;
        int ks;
        model_reset();
        repeat (3) @(negedge Clk);
        check("reset_x", 64'(meteor_x), 64'd0);
        check("reset_y", 64'(meteor_y), 64'd0);
        check("reset_active", 64'(meteor_active), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_count", 64'(spawn_count), 64'd0);
        Reset = 1'b0;

        // First spawn after the interval, seed 700 wraps to 60.
        enable = 1'b1;
        set_rand(700, 2, 3, 0);
        repeat (3) run_frame('0, -1, 0);
        check("spawn0_x", 64'(meteor_x[9:0]), 64'd60);
        check("spawn0_y", 64'(meteor_y[9:0]), 64'd0);
        check("spawn0_active", 64'(meteor_active), 64'b0001);
        check("spawn0_count", 64'(spawn_count), 64'd1);
        run_frame('0, -1, 0);
        check("move0_x", 64'(meteor_x[9:0]), 64'd62);
        check("move0_y", 64'(meteor_y[9:0]), 64'd3);

        // Leftward meteor at x=1 with vx=2 underflows next frame.
        set_rand(1, 2, 0, 1);
        repeat (2) run_frame('0, -1, 0);
        check("spawn1_x", 64'(meteor_x[19:10]), 64'd1);
        check("spawn1_active", 64'(meteor_active), 64'b0011);
        run_frame('0, -1, 0);
        check("left_exit_active", 64'(meteor_active), 64'b0001);

        // Randomized frames.
        repeat (300) begin
            set_rand($urandom_range(0, 1023), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1));
            enable = ($urandom_range(0, 9) != 0);
            km = ($urandom_range(0, 7) == 0) ? 4'($urandom) : '0;
            ks = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 7) : -1;
            run_frame(km, ks, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) kill_idle($urandom_range(0, 7));
            repeat ($urandom_range(0, 2)) @(negedge Clk);
        end

        // Reset in the middle of MOVE clears everything at once.
        @(negedge Clk); frame_tick = 1'b1;
        @(negedge Clk); frame_tick = 1'b0;
        @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        check("midreset_x", 64'(meteor_x), 64'd0);
        check("midreset_y", 64'(meteor_y), 64'd0);
        check("midreset_active", 64'(meteor_active), 64'd0);
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_count", 64'(spawn_count), 64'd0);
        exp_q.delete();
        model_reset();
        repeat (2) @(negedge Clk);
        Reset = 1'b0;

        // Zero y speed is stored as 1; ticks during busy must not add extra moves.
        enable = 1'b1;
        set_rand(100, 0, 0, 0);
        repeat (4) run_frame('0, -1, 1);
        check("vy_forced_y", 64'(meteor_y[9:0]), 64'd1);
        repeat (8) run_frame('0, -1, 1);
        check("full_active", 64'(meteor_active), 64'hF);
        check("full_count", 64'(spawn_count), 64'd4);
        check("single_advance_y", 64'(meteor_y[9:0]), 64'd9);
        repeat (6) run_frame('0, -1, 0);
        check("full_hold_count", 64'(spawn_count), 64'd4);
        kill_idle(2);
        run_frame('0, -1, 0);
        check("refill_active", 64'(meteor_active), 64'hF);
        check("refill_count", 64'(spawn_count), 64'd5);
        check("refill_y", 64'(meteor_y[29:20]), 64'd0);

        // Spawning disabled; movement continues.
        enable = 1'b0;
        repeat (40) run_frame('0, -1, 0);
        check("disabled_count", 64'(spawn_count), 64'd5);
        run_frame(4'b0010, -1, 0);
        check("kill_during_move", 64'(meteor_active), 64'b1101);

        repeat (3) @(negedge Clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
